// File: rtl/bcp_engine_pkg.sv
// Shared definitions for the BCP engine slice.
//   - Sizing constants for variables, clauses and literals.
//   - lit_t: one clause literal, packed as {valid, neg, var_id}.
//   - bcp_state_t: scan FSM states.
package bcp_engine_pkg;

  localparam int MAX_VARS         = 16;
  localparam int MAX_VARS_BITS    = 4;
  localparam int MAX_CLAUSES_BITS = 4;
  localparam int LITS             = 3;
  localparam int LIT_W            = MAX_VARS_BITS + 2;
  localparam int CLAUSE_W         = LITS * LIT_W;

  typedef struct packed {
    logic                     valid;
    logic                     neg;
    logic [MAX_VARS_BITS-1:0] var_id;
  } lit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_STALL
  } bcp_state_t;

endpackage

// File: rtl/bcp_engine_clause_eval.sv
// clause_eval: purely combinational evaluation of one clause against the
// effective variable state (solver assignment overlaid by the pending map).
// Ports:
//   clause          in  packed literals, literal 0 in the LSBs
//   var_val         in  assigned value per variable
//   var_unassigned  in  1 = variable unassigned in the solver
//   pend, pend_val  in  implications already pushed during this pass
//   sat             out some literal is true
//   unit            out not sat, exactly one valid literal unassigned
//   conflict        out not sat, no valid literal unassigned
//   unit_var        out variable of the open literal (meaningful with unit)
//   unit_val        out value that makes that literal true
module clause_eval
  import bcp_engine_pkg::*;
(
  input  logic [CLAUSE_W-1:0]      clause,
  input  logic [MAX_VARS-1:0]      var_val,
  input  logic [MAX_VARS-1:0]      var_unassigned,
  input  logic [MAX_VARS-1:0]      pend,
  input  logic [MAX_VARS-1:0]      pend_val,
  output logic                     sat,
  output logic                     unit,
  output logic                     conflict,
  output logic [MAX_VARS_BITS-1:0] unit_var,
  output logic                     unit_val
);

  lit_t             lits [LITS];
  logic [LITS-1:0]  lit_true;
  logic [LITS-1:0]  lit_open;
  logic [1:0]       n_open;

  // A pending implication counts as an assignment, so a clause that would
  // contradict an earlier push in this pass resolves as a conflict.
  always_comb begin
    for (int i = 0; i < LITS; i++) begin
      lits[i]     = lit_t'(clause[i*LIT_W +: LIT_W]);
      lit_true[i] = lits[i].valid
                    && (!var_unassigned[lits[i].var_id] || pend[lits[i].var_id])
                    && ((pend[lits[i].var_id] ? pend_val[lits[i].var_id]
                                              : var_val[lits[i].var_id]) != lits[i].neg);
      lit_open[i] = lits[i].valid
                    && var_unassigned[lits[i].var_id] && !pend[lits[i].var_id];
    end
  end

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    n_open   = '0;
    unit_var = '0;
    unit_val = 1'b0;
    for (int i = 0; i < LITS; i++) begin
      if (lit_open[i]) begin
        n_open   = n_open + 2'd1;
        unit_var = lits[i].var_id;
        unit_val = ~lits[i].neg;
      end
    end
    sat      = |lit_true;
    unit     = !sat && (n_open == 2'd1);
    conflict = !sat && (n_open == 2'd0);
  end

endmodule

// File: rtl/bcp_engine.sv
// bcp_engine: boolean-constraint-propagation responder for the DPLL solver.
// On bcp_en it scans clauses [start_clause, end_clause], pushes unit
// implications onto the imply stack and stops at the first conflicting clause.
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   reset_bcp           synchronous abort from control, same effect as reset
//   bcp_en              start request, accepted only when idle
//   start_clause        first clause of the scan (latched with bcp_en)
//   end_clause          last clause of the scan, inclusive
//   bcp_busy            registered, high while scanning
//   conflict            sticky result of the last pass
//   bcp_clause_idx      index of the conflicting clause
//   clause_read         clause memory read strobe
//   clause_addr         clause memory read address
//   clause_data         clause word, valid the cycle after clause_read
//   var_val             assigned value per variable
//   var_unassigned      1 = variable unassigned
//   push_imply          one-cycle imply stack push strobe
//   var_in_imply        pushed variable
//   val_in_imply        pushed value
//   full_imply          imply stack full, defers a push
module bcp_engine
  import bcp_engine_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        reset_bcp,
  input  logic                        bcp_en,
  input  logic [MAX_CLAUSES_BITS-1:0] start_clause,
  input  logic [MAX_CLAUSES_BITS-1:0] end_clause,
  output logic                        bcp_busy,
  output logic                        conflict,
  output logic [MAX_CLAUSES_BITS-1:0] bcp_clause_idx,
  output logic                        clause_read,
  output logic [MAX_CLAUSES_BITS-1:0] clause_addr,
  input  logic [CLAUSE_W-1:0]         clause_data,
  input  logic [MAX_VARS-1:0]         var_val,
  input  logic [MAX_VARS-1:0]         var_unassigned,
  output logic                        push_imply,
  output logic [MAX_VARS_BITS-1:0]    var_in_imply,
  output logic                        val_in_imply,
  input  logic                        full_imply
);

  bcp_state_t state, next_state;

  // One extra bit so that end_clause at the maximum index terminates the
  // scan instead of wrapping back to clause 0.
  logic [MAX_CLAUSES_BITS:0]   idx;
  logic [MAX_CLAUSES_BITS-1:0] end_q;
  logic [MAX_VARS-1:0]         pend, pend_val;
  logic [MAX_VARS_BITS-1:0]    hold_var;
  logic                        hold_val;

  logic                        c_sat, c_unit, c_conflict;
  logic [MAX_VARS_BITS-1:0]    c_unit_var;
  logic                        c_unit_val;
  logic                        past_end, dup;

  logic                        accept, do_push, do_inc, do_conflict, hold_load;
  logic [MAX_VARS_BITS-1:0]    push_var;
  logic                        push_val;

  clause_eval u_clause_eval (
    .clause         (clause_data),
    .var_val        (var_val),
    .var_unassigned (var_unassigned),
    .pend           (pend),
    .pend_val       (pend_val),
    .sat            (c_sat),
    .unit           (c_unit),
    .conflict       (c_conflict),
    .unit_var       (c_unit_var),
    .unit_val       (c_unit_val)
  );

  assign past_end    = idx > {1'b0, end_q};
  assign dup         = pend[c_unit_var] && (pend_val[c_unit_var] == c_unit_val);
  assign clause_read = (state == ST_READ) && !past_end;
  assign clause_addr = clause_read ? idx[MAX_CLAUSES_BITS-1:0] : '0;

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    do_push     = 1'b0;
    do_inc      = 1'b0;
    do_conflict = 1'b0;
    hold_load   = 1'b0;
    push_var    = c_unit_var;
    push_val    = c_unit_val;
    unique case (state)
      ST_IDLE: begin
        if (bcp_en) begin
          accept     = 1'b1;
          next_state = ST_READ;
        end
      end
      ST_READ: begin
        next_state = past_end ? ST_IDLE : ST_EVAL;
      end
      ST_EVAL: begin
        if (c_conflict) begin
          do_conflict = 1'b1;
          next_state  = ST_IDLE;
        end else if (c_unit && !dup) begin
          if (full_imply) begin
            hold_load  = 1'b1;
            next_state = ST_STALL;
          end else begin
            do_push    = 1'b1;
            do_inc     = 1'b1;
            next_state = ST_READ;
          end
        end else begin
          do_inc     = 1'b1;
          next_state = ST_READ;
        end
      end
      ST_STALL: begin
        push_var = hold_var;
        push_val = hold_val;
        if (!full_imply) begin
          do_push    = 1'b1;
          do_inc     = 1'b1;
          next_state = ST_READ;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || reset_bcp) begin
      state          <= ST_IDLE;
      idx            <= '0;
      end_q          <= '0;
      // NOTE: the pending map is a handful of flops, not a RAM, and must be
      // cleared on every abort, so it is reset along with the control state.
      pend           <= '0;
      pend_val       <= '0;
      hold_var       <= '0;
      hold_val       <= 1'b0;
      bcp_busy       <= 1'b0;
      conflict       <= 1'b0;
      bcp_clause_idx <= '0;
      push_imply     <= 1'b0;
      var_in_imply   <= '0;
      val_in_imply   <= 1'b0;
    end else begin
      state      <= next_state;
      bcp_busy   <= (next_state != ST_IDLE);
      push_imply <= do_push;

      if (accept) begin
        idx            <= {1'b0, start_clause};
        end_q          <= end_clause;
        conflict       <= 1'b0;
        bcp_clause_idx <= '0;
      end
      if (do_inc) begin
        idx <= idx + 1'b1;
      end
      if (do_conflict) begin
        conflict       <= 1'b1;
        bcp_clause_idx <= idx[MAX_CLAUSES_BITS-1:0];
      end
      if (hold_load) begin
        hold_var <= c_unit_var;
        hold_val <= c_unit_val;
      end
      if (do_push) begin
        var_in_imply       <= push_var;
        val_in_imply       <= push_val;
        pend[push_var]     <= 1'b1;
        pend_val[push_var] <= push_val;
      end
    end
  end

endmodule

// File: tb/tb_bcp_engine.sv
// Directed self-checking bench for bcp_engine with a clause memory model and
// negedge monitors counting busy cycles, pushes and read addresses.
module tb_bcp_engine;
  import bcp_engine_pkg::*;

  logic                        clock = 1'b0;
  logic                        reset, reset_bcp, bcp_en, full_imply;
  logic [MAX_CLAUSES_BITS-1:0] start_clause, end_clause;
  logic                        bcp_busy, conflict, clause_read;
  logic [MAX_CLAUSES_BITS-1:0] bcp_clause_idx, clause_addr;
  logic [CLAUSE_W-1:0]         clause_data = '0;
  logic [MAX_VARS-1:0]         var_val, var_unassigned;
  logic                        push_imply, val_in_imply;
  logic [MAX_VARS_BITS-1:0]    var_in_imply;

  logic [CLAUSE_W-1:0]         mem [16];
  int                          checks = 0;
  int                          errors = 0;
  int                          busy_cycles, push_count;
  logic [MAX_VARS_BITS-1:0]    last_var;
  logic                        last_val;
  logic [15:0]                 read_hit;

  always #5 clock = ~clock;

  bcp_engine dut (
    .clock          (clock),
    .reset          (reset),
    .reset_bcp      (reset_bcp),
    .bcp_en         (bcp_en),
    .start_clause   (start_clause),
    .end_clause     (end_clause),
    .bcp_busy       (bcp_busy),
    .conflict       (conflict),
    .bcp_clause_idx (bcp_clause_idx),
    .clause_read    (clause_read),
    .clause_addr    (clause_addr),
    .clause_data    (clause_data),
    .var_val        (var_val),
    .var_unassigned (var_unassigned),
    .push_imply     (push_imply),
    .var_in_imply   (var_in_imply),
    .val_in_imply   (val_in_imply),
    .full_imply     (full_imply)
  );

  // Clause memory: one-cycle read latency.
  always @(posedge clock) begin
    if (clause_read) clause_data <= mem[clause_addr];
  end

  always @(negedge clock) begin
    if (bcp_busy) busy_cycles++;
    if (push_imply) begin
      push_count++;
      last_var = var_in_imply;
      last_val = val_in_imply;
    end
    if (clause_read) read_hit[clause_addr] = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [LIT_W-1:0] mk_lit(input logic v, input logic n,
                                              input logic [MAX_VARS_BITS-1:0] id);
    return {v, n, id};
  endfunction

  function automatic logic [CLAUSE_W-1:0] mk_clause(input logic [LIT_W-1:0] l0,
                                                    input logic [LIT_W-1:0] l1,
                                                    input logic [LIT_W-1:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_stats();
    busy_cycles = 0;
    push_count  = 0;
    last_var    = '0;
    last_val    = 1'b0;
    read_hit    = '0;
  endtask

  task automatic clear_pend();
    reset_bcp = 1'b1;
    tick();
    reset_bcp = 1'b0;
  endtask

  task automatic start(input int s, input int e);
    start_clause = MAX_CLAUSES_BITS'(s);
    end_clause   = MAX_CLAUSES_BITS'(e);
    bcp_en       = 1'b1;
    tick();
    bcp_en       = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && bcp_busy; i++) tick();
    check("busy_timeout", bcp_busy, 0);
  endtask

  task automatic run_pass(input int s, input int e);
    clear_stats();
    start(s, e);
    wait_idle();
  endtask

  initial begin
    // x1 = 0, x2 = 1 assigned; every other variable unassigned.
    var_val        = 16'h0004;
    var_unassigned = 16'hFFF9;
    full_imply     = 1'b0;
    reset_bcp      = 1'b0;
    start_clause   = '0;
    end_clause     = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    clear_stats();

    // Reset with bcp_en asserted: nothing starts, all outputs zero.
    reset  = 1'b1;
    bcp_en = 1'b1;
    tick();
    tick();
    check("rst_busy", bcp_busy, 0);
    check("rst_conflict", conflict, 0);
    check("rst_idx", bcp_clause_idx, 0);
    check("rst_push", push_imply, 0);
    check("rst_read", clause_read, 0);
    check("rst_addr", clause_addr, 0);
    check("rst_var", var_in_imply, 0);
    reset  = 1'b0;
    bcp_en = 1'b0;
    tick();
    check("rst_no_start", bcp_busy, 0);

    // Unit: (x1 | ~x2 | x3) with x1=0, x2=1 implies x3=1.
    mem[0] = mk_clause(mk_lit(1, 0, 1), mk_lit(1, 1, 2), mk_lit(1, 0, 3));
    run_pass(0, 0);
    check("unit_pushes", push_count, 1);
    check("unit_var", last_var, 3);
    check("unit_val", last_val, 1);
    check("unit_busy", busy_cycles, 3);
    check("unit_conflict", conflict, 0);

    // Early stop: clause 5 all false; clauses 3,4 read and evaluated,
    // clause 5 read and evaluated, then idle: 6 busy cycles.
    clear_pend();
    mem[3] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    mem[4] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    mem[5] = mk_clause(mk_lit(1, 0, 1), mk_lit(1, 1, 2), '0);
    mem[6] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    mem[7] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    run_pass(3, 7);
    check("stop_conflict", conflict, 1);
    check("stop_idx", bcp_clause_idx, 5);
    check("stop_read5", read_hit[5], 1);
    check("stop_no_read6", read_hit[6], 0);
    check("stop_busy", busy_cycles, 6);
    check("stop_pushes", push_count, 0);
    tick();
    tick();
    check("stop_hold_conflict", conflict, 1);
    check("stop_hold_idx", bcp_clause_idx, 5);

    // Contradiction: clause 0 implies x4=1, clause 1 then needs x4=0.
    clear_pend();
    mem[0] = mk_clause(mk_lit(1, 0, 4), mk_lit(1, 0, 1), '0);
    mem[1] = mk_clause(mk_lit(1, 1, 4), mk_lit(1, 0, 1), '0);
    run_pass(0, 1);
    check("contra_pushes", push_count, 1);
    check("contra_var", last_var, 4);
    check("contra_val", last_val, 1);
    check("contra_conflict", conflict, 1);
    check("contra_idx", bcp_clause_idx, 1);
    check("contra_busy", busy_cycles, 4);

    // Duplicate: both clauses imply x6=0; the second is satisfied by pend.
    clear_pend();
    mem[0] = mk_clause(mk_lit(1, 1, 6), mk_lit(1, 0, 1), '0);
    mem[1] = mk_clause(mk_lit(1, 1, 2), mk_lit(1, 1, 6), '0);
    run_pass(0, 1);
    check("dup_pushes", push_count, 1);
    check("dup_var", last_var, 6);
    check("dup_val", last_val, 0);
    check("dup_conflict_cleared", conflict, 0);
    check("dup_busy", busy_cycles, 5);

    // Stall: full_imply held so three STALL cycles precede the push.
    // READ, EVAL, STALL x3, READ, EVAL, READ = 8 busy cycles.
    clear_pend();
    clear_stats();
    full_imply = 1'b1;
    start(0, 1);
    repeat (4) tick();
    check("stall_no_push", push_count, 0);
    check("stall_busy", bcp_busy, 1);
    full_imply = 1'b0;
    wait_idle();
    check("stall_pushes", push_count, 1);
    check("stall_var", last_var, 6);
    check("stall_val", last_val, 0);
    check("stall_busy_cycles", busy_cycles, 8);

    // bcp_en while busy is ignored: clause 5 (a conflict) is never read.
    clear_pend();
    mem[0] = mk_clause(mk_lit(1, 0, 1), mk_lit(1, 1, 2), mk_lit(1, 0, 3));
    mem[1] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    mem[2] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    mem[3] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    clear_stats();
    start(0, 3);
    start(5, 5);
    wait_idle();
    check("ign_no_read5", read_hit[5], 0);
    check("ign_conflict", conflict, 0);
    check("ign_busy", busy_cycles, 9);
    check("ign_pushes", push_count, 1);

    // Abort mid-scan, then a rerun re-pushes x3=1 since pend was cleared.
    clear_pend();
    clear_stats();
    start(0, 3);
    for (int i = 0; i < 20 && push_count == 0; i++) tick();
    check("abort_saw_push", push_count, 1);
    check("abort_busy_before", bcp_busy, 1);
    reset_bcp = 1'b1;
    tick();
    reset_bcp = 1'b0;
    check("abort_busy", bcp_busy, 0);
    check("abort_push", push_imply, 0);
    check("abort_read", clause_read, 0);
    run_pass(0, 0);
    check("abort_repush", push_count, 1);
    check("abort_repush_var", last_var, 3);
    check("abort_repush_val", last_val, 1);

    // Range ending at the maximum index must not wrap to clause 0.
    clear_pend();
    mem[14] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    mem[15] = mk_clause(mk_lit(1, 1, 1), '0, '0);
    run_pass(14, 15);
    check("max_busy", busy_cycles, 5);
    check("max_read15", read_hit[15], 1);
    check("max_no_wrap", read_hit[0], 0);

    // Empty range: start > end gives one busy cycle and no reads.
    run_pass(5, 4);
    check("empty_busy", busy_cycles, 1);
    check("empty_reads", read_hit, 0);
    check("empty_conflict", conflict, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
